// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexes DIGITS hex nibbles onto a shared 7-segment bus with anti-ghost blanking
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lz_blank,
  input  logic [4*DIGITS-1:0]   digit_values,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] slot_cnt, slot_n;
  logic [IW-1:0] idx, idx_n;
  logic [4*DIGITS-1:0] snap_val;
  logic [DIGITS-1:0] snap_dp, lz_mask, an_n;
  logic snap_lz, take, slot_end, last_digit, dp_n, fd_n, z;
  logic [3:0] nib;
  logic [6:0] seg_n;
  assign slot_end = slot_cnt == LAST_CNT;
  assign last_digit = idx == LAST_IDX;
  assign nib = snap_val[4*idx +: 4];
  // next-state: slot counter drives BLANK/SHOW, slot end advances digit, wrap re-snapshots
  always_comb begin
    state_n = state;
    idx_n = idx;
    slot_n = slot_cnt;
    take = 1'b0;
    if (state == IDLE) begin
      if (en) begin
        state_n = BLANK;
        idx_n = '0;
        slot_n = '0;
        take = 1'b1;
      end
    end else if (!en) begin
      state_n = IDLE;
      idx_n = '0;
      slot_n = '0;
    end else begin
      slot_n = slot_end ? '0 : slot_cnt + CW'(1);
      state_n = slot_n < BLANK_END ? BLANK : SHOW;
      if (slot_end) begin
        idx_n = last_digit ? '0 : idx + IW'(1);
        take = last_digit;
      end
    end
  end
  // leading-zero mask: digit i blank when it and every higher snapshot nibble is zero
  always_comb begin
    lz_mask = '0;
    z = snap_lz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z = z & (snap_val[4*i +: 4] == 4'd0);
      lz_mask[i] = z && (i != 0);
    end
  end
  // output decode from current state; forced dark when idle or when en drops
  always_comb begin
    an_n = '1;
    seg_n = 7'h7F;
    dp_n = 1'b1;
    fd_n = 1'b0;
    if (state != IDLE && en) begin
      seg_n = lz_mask[idx] ? 7'h7F : HEX[nib];
      dp_n = ~snap_dp[idx];
      an_n[idx] = state != SHOW;
      fd_n = state == SHOW && last_digit && slot_end;
    end
  end
  // state, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      slot_cnt <= '0;
      snap_val <= '0;
      snap_dp <= '0;
      snap_lz <= 1'b0;
      an <= '1;
      seg <= 7'h7F;
      dp <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      slot_cnt <= slot_n;
      if (take) begin
        snap_val <= digit_values;
        snap_dp <= dp_in;
        snap_lz <= lz_blank;
      end
      an <= an_n;
      seg <= seg_n;
      dp <= dp_n;
      frame_done <= fd_n;
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: scoreboard bench for the multi-digit scan controller
module tb_display_scan_controller;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic clk = 1'b0, rst = 1'b0, en = 1'b1, lz_blank = 1'b0;
  logic [15:0] digit_values = 16'h1234;
  logic [3:0] dp_in = 4'b0000, an;
  logic [6:0] seg;
  logic dp, frame_done;
  int n_tests = 0, n_fail = 0;
  logic [12:0] sb [$];
  logic active = 1'b0;
  int t = 0;
  logic [15:0] m_val;
  logic [3:0] m_dp;
  logic m_lz;

  display_scan_controller #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .lz_blank(lz_blank), .digit_values(digit_values),
    .dp_in(dp_in), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: time since activation t picks digit t/8 and phase t%8
  always @(posedge clk) begin
    logic [12:0] e;
    int d, ph;
    logic blank;
    e = {4'b1111, 7'h7F, 1'b1, 1'b0};
    if (!rst || !en) active = 1'b0;
    else if (!active) begin
      active = 1'b1;
      t = 0;
      m_val = digit_values;
      m_dp = dp_in;
      m_lz = lz_blank;
    end else begin
      d = (t / 8) % 4;
      ph = t % 8;
      blank = m_lz && d != 0 && (m_val >> (4 * d)) == 16'd0;
      e[12:9] = ph < 2 ? 4'b1111 : ~(4'b0001 << d);
      e[8:2] = blank ? 7'h7F : HEX[(m_val >> (4 * d)) & 16'hF];
      e[1] = ~m_dp[d];
      e[0] = (t % 32) == 31;
      if ((t % 32) == 31) begin
        m_val = digit_values;
        m_dp = dp_in;
        m_lz = lz_blank;
      end
      t++;
    end
    sb.push_back(e);
  end

  // compare DUT outputs against the scoreboard half a cycle after each edge
  always @(negedge clk) begin
    logic [12:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("an", an, e[12:9]);
      check("seg", seg, e[8:2]);
      check("dp", dp, e[1]);
      check("frame_done", frame_done, e[0]);
      check("one_anode", $countones(~an) <= 1, 1);
    end
  end

  task automatic wait_an(input logic [3:0] target);
    for (int k = 0; k < 100 && an !== target; k++) @(negedge clk);
    check("wait_an", an, target);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_fd", frame_done, 0);
    rst = 1'b1;
    wait_an(4'b1110);
    check("scan_d0", seg, 7'b0011001);
    wait_an(4'b1101);
    digit_values = 16'hABCD;
    wait_an(4'b1011);
    check("snap_d2", seg, 7'b0100100);
    wait_an(4'b0111);
    check("snap_d3", seg, 7'b1111001);
    wait_an(4'b1110);
    check("new_frame_d0", seg, 7'b0100001);
    digit_values = 16'h0050;
    lz_blank = 1'b1;
    repeat (40) @(negedge clk);
    wait_an(4'b1110);
    check("lz_d0", seg, 7'b1000000);
    wait_an(4'b1101);
    check("lz_d1", seg, 7'b0010010);
    wait_an(4'b1011);
    check("lz_d2", seg, 7'h7F);
    wait_an(4'b0111);
    check("lz_d3", seg, 7'h7F);
    digit_values = 16'h0000;
    repeat (40) @(negedge clk);
    wait_an(4'b1110);
    check("lz0_d0", seg, 7'b1000000);
    wait_an(4'b1101);
    check("lz0_d1", seg, 7'h7F);
    lz_blank = 1'b0;
    digit_values = 16'h1234;
    repeat (40) @(negedge clk);
    wait_an(4'b1011);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_an", an, 4'b1111);
    digit_values = 16'h5678;
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_an(4'b1110);
    check("restart_d0", seg, 7'b0000000);
    dp_in = 4'b1000;
    repeat (40) @(negedge clk);
    wait_an(4'b0111);
    check("wrap_dp3", dp, 0);
    wait_an(4'b1110);
    check("wrap_dp0", dp, 1);
    wait_an(4'b0111);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_fd", frame_done, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
